// File: rtl/vga_scan_gen.sv
// Pixel-timing generator for the 640x480@60 Hz VGA path: pixel-tick divider,
// scan counters, and sync/blank decodes delayed to match downstream read latency.
module vga_scan_gen #(
   parameter int unsigned CLK_DIV  = 2,
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter int unsigned SYNC_DLY = 2
) (
   input  logic       clk,
   input  logic       rst,
   output logic       pix_en,
   output logic [9:0] c,
   output logic [9:0] r,
   output logic       hsync,
   output logic       vsync,
   output logic       active,
   output logic       line_start,
   output logic       frame_start,
   output logic [7:0] frame_cnt
);

   localparam int unsigned CW       = 10;
   localparam int unsigned DW       = 4;
   localparam int unsigned FW       = 8;
   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_START = H_ACTIVE + H_FP;
   localparam int unsigned HS_END   = HS_START + H_SYNC;
   localparam int unsigned VS_START = V_ACTIVE + V_FP;
   localparam int unsigned VS_END   = VS_START + V_SYNC;

   logic [DW-1:0] div_cnt;
   logic          hs_raw;
   logic          vs_raw;
   logic          active_raw;
   logic [2:0]    dly [SYNC_DLY];

   // Pixel-tick divider; with CLK_DIV=1 the compare is always true so pix_en stays high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
         pix_en  <= 1'(CLK_DIV == 1);
      end else begin
         div_cnt <= (div_cnt == DW'(CLK_DIV - 1)) ? '0 : div_cnt + DW'(1);
         pix_en  <= (div_cnt == DW'(CLK_DIV - 1));
      end
   end

   // Column, row and frame counters advance once per pixel tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c         <= '0;
         r         <= '0;
         frame_cnt <= '0;
      end else if (pix_en) begin
         if (c == CW'(H_TOTAL - 1)) begin
            c <= '0;
            if (r == CW'(V_TOTAL - 1)) begin
               r         <= '0;
               frame_cnt <= frame_cnt + FW'(1);
            end else begin
               r <= r + CW'(1);
            end
         end else begin
            c <= c + CW'(1);
         end
      end
   end

   always_comb begin
      active_raw = (c < CW'(H_ACTIVE)) && (r < CW'(V_ACTIVE));
      hs_raw     = !((c >= CW'(HS_START)) && (c < CW'(HS_END)));
      vs_raw     = !((r >= CW'(VS_START)) && (r < CW'(VS_END)));
   end

   // Delay line for {hsync, vsync, active}; idle pattern is syncs high, blanked.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(SYNC_DLY); i++) dly[i] <= 3'b110;
      end else if (pix_en) begin
         dly[0] <= {hs_raw, vs_raw, active_raw};
         for (int i = 1; i < int'(SYNC_DLY); i++) dly[i] <= dly[i-1];
      end
   end

   assign {hsync, vsync, active} = dly[SYNC_DLY-1];

   always_comb begin
      line_start  = pix_en && (c == CW'(H_TOTAL - 1));
      frame_start = line_start && (r == CW'(V_TOTAL - 1));
   end

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen: a default-timing instance and a shrunk-timing CLK_DIV=1
// instance, both checked every cycle against an arithmetic model of elapsed ticks.
module tb_vga_scan_gen;

   // Shrunk timing for instance b: 8 ticks/line, 6 lines/frame, 48 ticks/frame.
   localparam int B_HA = 4, B_HFP = 1, B_HS = 2, B_HBP = 1;
   localparam int B_VA = 3, B_VFP = 1, B_VS = 1, B_VBP = 1;
   localparam int B_DIV = 1, B_DLY = 3;

   typedef struct packed {
      logic       pix_en;
      logic [9:0] c;
      logic [9:0] r;
      logic       hsync;
      logic       vsync;
      logic       active;
      logic       line_start;
      logic       frame_start;
      logic [7:0] frame_cnt;
   } obs_t;

   logic clk = 1'b0;
   logic rst_a = 1'b0;
   logic rst_b = 1'b0;
   always #5 clk = ~clk;

   logic       pix_en_a, hsync_a, vsync_a, active_a, line_start_a, frame_start_a;
   logic [9:0] c_a, r_a;
   logic [7:0] frame_cnt_a;
   logic       pix_en_b, hsync_b, vsync_b, active_b, line_start_b, frame_start_b;
   logic [9:0] c_b, r_b;
   logic [7:0] frame_cnt_b;

   vga_scan_gen dut_a (
      .clk(clk), .rst(rst_a), .pix_en(pix_en_a), .c(c_a), .r(r_a),
      .hsync(hsync_a), .vsync(vsync_a), .active(active_a),
      .line_start(line_start_a), .frame_start(frame_start_a), .frame_cnt(frame_cnt_a)
   );

   vga_scan_gen #(
      .CLK_DIV(B_DIV), .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
      .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP), .SYNC_DLY(B_DLY)
   ) dut_b (
      .clk(clk), .rst(rst_b), .pix_en(pix_en_b), .c(c_b), .r(r_b),
      .hsync(hsync_b), .vsync(vsync_b), .active(active_b),
      .line_start(line_start_b), .frame_start(frame_start_b), .frame_cnt(frame_cnt_b)
   );

   obs_t obs_a, obs_b;
   assign obs_a = {pix_en_a, c_a, r_a, hsync_a, vsync_a, active_a,
                   line_start_a, frame_start_a, frame_cnt_a};
   assign obs_b = {pix_en_b, c_b, r_b, hsync_b, vsync_b, active_b,
                   line_start_b, frame_start_b, frame_cnt_b};

   int checks = 0;
   int errors = 0;

   // Rising edges seen since the last reset release.
   int k_a = 0;
   int k_b = 0;
   always @(posedge clk or posedge rst_a) if (rst_a) k_a <= 0; else k_a <= k_a + 1;
   always @(posedge clk or posedge rst_b) if (rst_b) k_b <= 0; else k_b <= k_b + 1;

   // Outputs after k edges: pixel ticks elapsed give coordinates by division,
   // and the delayed flags are the decode of the tick count sd ticks earlier.
   function automatic obs_t model(int k, int div, int ha, int hfp, int hs, int hbp,
                                  int va, int vfp, int vs, int vbp, int sd);
      obs_t o;
      int ht, vt, t, td, dc, dr, cc, rr;
      ht = ha + hfp + hs + hbp;
      vt = va + vfp + vs + vbp;
      if (div == 1) begin
         o.pix_en = 1'b1;
         t = k;
      end else begin
         o.pix_en = (k >= 1) && (k % div == 0);
         t = (k >= 1) ? (k - 1) / div : 0;
      end
      cc = t % ht;
      rr = (t / ht) % vt;
      o.c = 10'(cc);
      o.r = 10'(rr);
      o.frame_cnt   = 8'((t / (ht * vt)) % 256);
      o.line_start  = o.pix_en && (cc == ht - 1);
      o.frame_start = o.line_start && (rr == vt - 1);
      if (t >= sd) begin
         td = t - sd;
         dc = td % ht;
         dr = (td / ht) % vt;
         o.active = (dc < ha) && (dr < va);
         o.hsync  = !((dc >= ha + hfp) && (dc < ha + hfp + hs));
         o.vsync  = !((dr >= va + vfp) && (dr < va + vfp + vs));
      end else begin
         o.active = 1'b0;
         o.hsync  = 1'b1;
         o.vsync  = 1'b1;
      end
      return o;
   endfunction

   task automatic check(string nm, int k, obs_t got, obs_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s k=%0d got pix=%b c=%0d r=%0d hs=%b vs=%b act=%b ls=%b fs=%b fc=%0d exp pix=%b c=%0d r=%0d hs=%b vs=%b act=%b ls=%b fs=%b fc=%0d",
                  nm, k, got.pix_en, got.c, got.r, got.hsync, got.vsync, got.active,
                  got.line_start, got.frame_start, got.frame_cnt,
                  exp.pix_en, exp.c, exp.r, exp.hsync, exp.vsync, exp.active,
                  exp.line_start, exp.frame_start, exp.frame_cnt);
      end
   endtask

   task automatic lit(string nm, int got, int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
      end
   endtask

   // Every-cycle comparison against the model for both instances.
   always @(negedge clk) begin
      if (checks >= 0 && $time > 2) begin
         check("scan_a", k_a, obs_a, model(k_a, 2, 640, 16, 96, 48, 480, 10, 2, 33, 2));
         check("scan_b", k_b, obs_b, model(k_b, B_DIV, B_HA, B_HFP, B_HS, B_HBP,
                                           B_VA, B_VFP, B_VS, B_VBP, B_DLY));
      end
   end

   // Assert reset between edges and confirm the outputs drop before any clock edge.
   task automatic pulse_rst_a(string nm);
      @(posedge clk);
      #1 rst_a = 1'b1;
      #1;
      lit({nm, "_c"}, int'(c_a), 0);
      lit({nm, "_r"}, int'(r_a), 0);
      lit({nm, "_pix"}, int'(pix_en_a), 0);
      lit({nm, "_syncs"}, int'({hsync_a, vsync_a, active_a}), 6);
      lit({nm, "_pulses"}, int'({line_start_a, frame_start_a}), 0);
      lit({nm, "_fc"}, int'(frame_cnt_a), 0);
      #1 rst_a = 1'b0;
   endtask

   task automatic pulse_rst_b(string nm);
      @(posedge clk);
      #1 rst_b = 1'b1;
      #1;
      lit({nm, "_c"}, int'(c_b), 0);
      lit({nm, "_r"}, int'(r_b), 0);
      lit({nm, "_pix"}, int'(pix_en_b), 1);
      lit({nm, "_syncs"}, int'({hsync_b, vsync_b, active_b}), 6);
      lit({nm, "_pulses"}, int'({line_start_b, frame_start_b}), 0);
      lit({nm, "_fc"}, int'(frame_cnt_b), 0);
      #1 rst_b = 1'b0;
   endtask

   task automatic seq_a();
      int hs_low, ls_cnt, act_cnt;
      hs_low = 0; ls_cnt = 0; act_cnt = 0;
      while (k_a < 1601) begin
         @(negedge clk);
         if (k_a >= 2 && k_a <= 1600 && pix_en_a) begin
            hs_low  += int'(!hsync_a);
            ls_cnt  += int'(line_start_a);
            act_cnt += int'(active_a);
         end
         case (k_a)
            2:    begin lit("a_first_tick", int'(pix_en_a), 1); lit("a_first_c", int'(c_a), 0); end
            3:    begin lit("a_tick_off", int'(pix_en_a), 0);  lit("a_c_inc", int'(c_a), 1); end
            1316: lit("a_hs_before", int'(hsync_a), 1);
            1317: lit("a_hs_start", int'(hsync_a), 0);
            1600: begin lit("a_ls_fire", int'(line_start_a), 1); lit("a_c_last", int'(c_a), 799); end
            1601: begin lit("a_row_inc", int'(r_a), 1); lit("a_c_wrap", int'(c_a), 0); end
            default: ;
         endcase
      end
      lit("a_hsync_low_ticks", hs_low, 96);
      lit("a_line_start_count", ls_cnt, 1);
      lit("a_active_ticks", act_cnt, 640);
      while (k_a < 2000) @(negedge clk);
      pulse_rst_a("a_rst_midline");
      repeat (4) begin
         repeat ($urandom_range(1, 3000)) @(negedge clk);
         pulse_rst_a("a_rst_rand");
      end
      repeat (50) @(negedge clk);
   endtask

   task automatic seq_b();
      int fs_cnt, last_fs, act_cnt, vs_low, hs_low;
      fs_cnt = 0; last_fs = -1; act_cnt = 0; vs_low = 0; hs_low = 0;
      while (k_b < 12336) begin
         @(negedge clk);
         if (k_b >= 3 && k_b <= 50) begin
            act_cnt += int'(active_b);
            vs_low  += int'(!vsync_b);
            hs_low  += int'(!hsync_b);
         end
         if (frame_start_b) begin
            fs_cnt++;
            if (last_fs >= 0) lit("b_frame_spacing", k_b - last_fs, 48);
            last_fs = k_b;
         end
      end
      lit("b_frame_starts", fs_cnt, 257);
      lit("b_frame_cnt_wrap", int'(frame_cnt_b), 1);
      lit("b_active_per_frame", act_cnt, 12);
      lit("b_vsync_low_ticks", vs_low, 8);
      lit("b_hsync_low_ticks", hs_low, 12);
      repeat (6) begin
         repeat ($urandom_range(1, 200)) @(negedge clk);
         pulse_rst_b("b_rst_rand");
      end
      repeat (60) @(negedge clk);
   endtask

   initial begin
      #1 rst_a = 1'b1; rst_b = 1'b1;
      repeat (3) @(negedge clk);
      lit("a_reset_pix", int'(pix_en_a), 0);
      lit("b_reset_pix", int'(pix_en_b), 1);
      rst_a = 1'b0;
      rst_b = 1'b0;
      fork
         seq_a();
         seq_b();
      join
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
